// File: rtl/bht_update_unit_if.sv
// EXE-side resolve inputs, PC-select outputs and BHT write-port handshake of bht_update_unit.
interface bht_update_unit_if #(
  parameter int unsigned PC_W = 10
);
  logic            exe_valid;
  logic [PC_W-1:0] exe_PC;
  logic [5:0]      exe_btype;
  logic            exe_is_jump;
  logic            exe_z;
  logic            exe_less;
  logic            exe_hit;
  logic [1:0]      exe_way;
  logic [1:0]      exe_counter;
  logic [PC_W-1:0] exe_target;
  logic [1:0]      exe_correction;
  logic [PC_W-1:0] exe_CNI;
  logic            flush;
  logic            stall;
  logic            upd_valid;
  logic            upd_ready;
  logic [5:0]      upd_index;
  logic [5:0]      upd_tag;
  logic [PC_W-1:0] upd_target;
  logic [1:0]      upd_counter;

  modport master (
    output exe_valid, exe_PC, exe_btype, exe_is_jump, exe_z, exe_less, exe_hit, exe_way,
           exe_counter, exe_target, upd_ready,
    input  exe_correction, exe_CNI, flush, stall, upd_valid, upd_index, upd_tag, upd_target,
           upd_counter
  );

  modport slave (
    input  exe_valid, exe_PC, exe_btype, exe_is_jump, exe_z, exe_less, exe_hit, exe_way,
           exe_counter, exe_target, upd_ready,
    output exe_correction, exe_CNI, flush, stall, upd_valid, upd_index, upd_tag, upd_target,
           upd_counter
  );
endinterface

// File: rtl/bht_update_unit.sv
// BHT write side: resolves EXE branches, drives PC correction, queues counter/target updates.
// Optional BHT_UPD_STATS_EN adds saturating 32-bit event counters as output ports.
module bht_update_unit #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 10
) (
  input  logic              CLK,
  input  logic              nrst,
`ifdef BHT_UPD_STATS_EN
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts,
  output logic [31:0]       stat_stalls,
`endif
  bht_update_unit_if.slave  bus
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  logic [5:0]      idx_mem_q [DEPTH];
  logic [5:0]      tag_mem_q [DEPTH];
  logic [PC_W-1:0] tgt_mem_q [DEPTH];
  logic [1:0]      ctr_mem_q [DEPTH];

  logic            is_br;
  logic            taken;
  logic            pred;
  logic [5:0]      lookup_idx;
  logic [1:0]      base_ctr;
  logic [1:0]      new_ctr;
  logic [PtrW-1:0] fwd_ptr;
  logic            full;
  logic            enq;
  logic            deq;
  logic            stall;
  logic [1:0]      correction;

  assign lookup_idx = {bus.exe_PC[3:0], bus.exe_way};
  assign is_br      = (|bus.exe_btype) | bus.exe_is_jump;
  assign taken      = bus.exe_is_jump
                    | (bus.exe_btype[5] & bus.exe_z)
                    | (bus.exe_btype[4] & ~bus.exe_z)
                    | ((bus.exe_btype[3] | bus.exe_btype[1]) & bus.exe_less)
                    | ((bus.exe_btype[2] | bus.exe_btype[0]) & ~bus.exe_less);

  // Youngest queued update to the same entry overrides the stale counter read at lookup.
  always_comb begin
    base_ctr = bus.exe_counter;
    fwd_ptr  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fwd_ptr = rd_ptr_q + PtrW'(i);
      if ((CntW'(i) < count_q) && (idx_mem_q[fwd_ptr] == lookup_idx)) begin
        base_ctr = ctr_mem_q[fwd_ptr];
      end
    end
  end

  always_comb begin
    new_ctr = base_ctr;
    if (bus.exe_is_jump) begin
      new_ctr = 2'b11;
    end else if (taken) begin
      if (base_ctr != 2'b11) new_ctr = base_ctr + 2'd1;
    end else begin
      if (base_ctr != 2'b00) new_ctr = base_ctr - 2'd1;
    end
  end

  assign pred  = bus.exe_hit & base_ctr[1];
  assign full  = (count_q == CntW'(DEPTH));
  assign deq   = (count_q != '0) & bus.upd_ready;
  assign stall = full & ~deq;
  assign enq   = bus.exe_valid & bus.exe_hit & is_br & ~stall;

  always_comb begin
    correction = 2'b00;
    if (bus.exe_valid && !stall && is_br) begin
      if (pred && !taken)      correction = 2'b10;
      else if (!pred && taken) correction = 2'b11;
    end
  end

  assign bus.exe_correction = correction;
  assign bus.flush          = correction[1];
  assign bus.stall          = stall;
  assign bus.exe_CNI        = bus.exe_PC + PC_W'(1);

  assign bus.upd_valid   = (count_q != '0);
  assign bus.upd_index   = idx_mem_q[rd_ptr_q];
  assign bus.upd_tag     = tag_mem_q[rd_ptr_q];
  assign bus.upd_target  = tgt_mem_q[rd_ptr_q];
  assign bus.upd_counter = ctr_mem_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({enq, deq})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: it is only observed while count_q marks it valid.
  always_ff @(posedge CLK) begin
    if (enq) begin
      idx_mem_q[wr_ptr_q] <= lookup_idx;
      tag_mem_q[wr_ptr_q] <= bus.exe_PC[9:4];
      tgt_mem_q[wr_ptr_q] <= bus.exe_target;
      ctr_mem_q[wr_ptr_q] <= new_ctr;
    end
  end

`ifdef BHT_UPD_STATS_EN
  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
      stat_stalls      <= '0;
    end else begin
      if (enq && stat_branches != '1)                stat_branches    <= stat_branches + 32'd1;
      if (correction[1] && stat_mispredicts != '1)   stat_mispredicts <= stat_mispredicts + 32'd1;
      if (stall && stat_stalls != '1)                stat_stalls      <= stat_stalls + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_bht_update_unit.sv
// Directed bench for bht_update_unit: expected updates go into a scoreboard drained by a monitor.
module tb_bht_update_unit;
  localparam logic [5:0] BEQ  = 6'b100000;
  localparam logic [5:0] BNE  = 6'b010000;
  localparam logic [5:0] BLT  = 6'b001000;
  localparam logic [5:0] BGE  = 6'b000100;
  localparam logic [5:0] BLTU = 6'b000010;
  localparam logic [5:0] BGEU = 6'b000001;
  localparam logic [5:0] NONE = 6'b000000;

  logic CLK;
  logic nrst;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [23:0] exp_q[$];

`ifdef BHT_UPD_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts, stat_stalls;
`endif

  bht_update_unit_if #(.PC_W(10)) bus ();

  bht_update_unit #(.DEPTH(4), .PC_W(10)) dut (
    .CLK              (CLK),
    .nrst             (nrst),
`ifdef BHT_UPD_STATS_EN
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts),
    .stat_stalls      (stat_stalls),
`endif
    .bus              (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Head is checked on every cycle where the DUT will dequeue at the following edge.
  always @(negedge CLK) begin
    if (nrst && bus.upd_valid && bus.upd_ready) begin
      if (exp_q.size() == 0) begin
        chk("upd_unexpected", {8'd0, bus.upd_index, bus.upd_tag, bus.upd_target,
                               bus.upd_counter}, 32'hFFFF_FFFF);
      end else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("upd_index",   32'(bus.upd_index),   32'(e[23:18]));
        chk("upd_tag",     32'(bus.upd_tag),     32'(e[17:12]));
        chk("upd_target",  32'(bus.upd_target),  32'(e[11:2]));
        chk("upd_counter", 32'(bus.upd_counter), 32'(e[1:0]));
      end
    end
  end

  task automatic idle(input bit rdy);
    @(posedge CLK); #1;
    bus.exe_valid = 1'b0;
    bus.upd_ready = rdy;
  endtask

  task automatic resolve(input bit vld, input logic [9:0] pc, input logic [5:0] bt,
                         input bit jmp, input bit z, input bit less, input bit hit,
                         input logic [1:0] way, input logic [1:0] ctr, input logic [9:0] tgt,
                         input bit rdy, input logic [1:0] exp_corr, input bit exp_stall,
                         input bit exp_enq, input logic [1:0] exp_ctr);
    logic [9:0] cni;
    @(posedge CLK); #1;
    bus.exe_valid   = vld;
    bus.exe_PC      = pc;
    bus.exe_btype   = bt;
    bus.exe_is_jump = jmp;
    bus.exe_z       = z;
    bus.exe_less    = less;
    bus.exe_hit     = hit;
    bus.exe_way     = way;
    bus.exe_counter = ctr;
    bus.exe_target  = tgt;
    bus.upd_ready   = rdy;
    #1;
    cni = pc + 10'd1;
    chk("correction", 32'(bus.exe_correction), 32'(exp_corr));
    chk("flush",      32'(bus.flush),          32'(exp_corr[1]));
    chk("stall",      32'(bus.stall),          32'(exp_stall));
    chk("cni",        32'(bus.exe_CNI),        32'(cni));
    if (exp_enq) exp_q.push_back({pc[3:0], way, pc[9:4], tgt, exp_ctr});
  endtask

  initial begin
    bus.exe_valid = 1'b0; bus.exe_PC = '0; bus.exe_btype = '0; bus.exe_is_jump = 1'b0;
    bus.exe_z = 1'b0; bus.exe_less = 1'b0; bus.exe_hit = 1'b0; bus.exe_way = '0;
    bus.exe_counter = '0; bus.exe_target = '0; bus.upd_ready = 1'b0;
    nrst = 1'b0;
    #2;
    chk("rst_upd_valid", 32'(bus.upd_valid), 0);
    chk("rst_stall",     32'(bus.stall),     0);
    chk("rst_flush",     32'(bus.flush),     0);
    chk("rst_corr",      32'(bus.exe_correction), 0);
    @(posedge CLK); #1 nrst = 1'b1;

    // Same index back to back with no drain: second resolve forwards the queued 10.
    resolve(1, 10'h084, BEQ, 0, 1, 0, 1, 2'd0, 2'b01, 10'h100, 0, 2'b11, 0, 1, 2'b10);
    resolve(1, 10'h084, BEQ, 0, 1, 0, 1, 2'd0, 2'b01, 10'h100, 0, 2'b00, 0, 1, 2'b11);
    // Fill to four, then the fifth stalls until the write port frees a slot.
    resolve(1, 10'h095, BLTU, 0, 0, 1, 1, 2'd1, 2'b10, 10'h111, 0, 2'b00, 0, 1, 2'b11);
    resolve(1, 10'h0A6, BGEU, 0, 0, 1, 1, 2'd2, 2'b01, 10'h122, 0, 2'b00, 0, 1, 2'b00);
    resolve(1, 10'h0B7, BEQ, 0, 0, 0, 1, 2'd3, 2'b11, 10'h133, 0, 2'b00, 1, 0, 2'b00);
    resolve(1, 10'h0B7, BEQ, 0, 0, 0, 1, 2'd3, 2'b11, 10'h133, 0, 2'b00, 1, 0, 2'b00);
    resolve(1, 10'h0B7, BEQ, 0, 0, 0, 1, 2'd3, 2'b11, 10'h133, 1, 2'b10, 0, 1, 2'b10);
    idle(1);
    // Three entries remain; reset mid-drain must discard them.
    @(posedge CLK); #1;
    nrst = 1'b0;
    bus.upd_ready = 1'b0;
    exp_q.delete();
    #1;
    chk("midrst_upd_valid", 32'(bus.upd_valid), 0);
    chk("midrst_stall",     32'(bus.stall),     0);
    @(posedge CLK); #1;
    chk("midrst_upd_valid2", 32'(bus.upd_valid), 0);
    nrst = 1'b1;

    resolve(1, 10'h012, BEQ, 0, 1, 0, 1, 2'd1, 2'b01, 10'h200, 1, 2'b11, 0, 1, 2'b10);
    resolve(1, 10'h025, BEQ, 0, 1, 0, 1, 2'd2, 2'b11, 10'h210, 1, 2'b00, 0, 1, 2'b11);
    resolve(1, 10'h036, BNE, 0, 1, 0, 1, 2'd0, 2'b10, 10'h220, 1, 2'b10, 0, 1, 2'b01);
    resolve(1, 10'h3FF, BNE, 0, 1, 0, 1, 2'd3, 2'b10, 10'h230, 1, 2'b10, 0, 1, 2'b01);
    resolve(1, 10'h040, BGE, 0, 0, 0, 0, 2'd0, 2'b00, 10'h240, 1, 2'b11, 0, 0, 2'b00);
    resolve(1, 10'h051, NONE, 1, 0, 0, 0, 2'd1, 2'b00, 10'h250, 1, 2'b11, 0, 0, 2'b00);
    resolve(1, 10'h062, NONE, 1, 0, 0, 1, 2'd1, 2'b00, 10'h260, 1, 2'b11, 0, 1, 2'b11);
    resolve(1, 10'h073, BLT, 0, 0, 0, 1, 2'd2, 2'b00, 10'h270, 1, 2'b00, 0, 1, 2'b00);
    resolve(0, 10'h084, BEQ, 0, 1, 0, 1, 2'd0, 2'b01, 10'h280, 1, 2'b00, 0, 0, 2'b00);

    for (int i = 0; i < 20 && (exp_q.size() != 0 || bus.upd_valid); i++) idle(1);
    idle(1);
    chk("drain_pending", 32'(exp_q.size()), 0);
    chk("drain_upd_valid", 32'(bus.upd_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
